// File: rtl/bit_merger.sv
// Merges a DW-bit data field and an AW-bit address field into one {addr, data}
// packet queued in a 2-entry output FIFO. Define BIT_MERGER_COUNT_EN to add pkt_count.
module bit_merger #(
  parameter int unsigned DW = 7,
  parameter int unsigned AW = 4
) (
  input  logic               CLK,
  input  logic               _RESET,
  input  logic [DW-1:0]      data_in,
  input  logic               data_valid,
  output logic               data_ready,
  input  logic [AW-1:0]      addr_in,
  input  logic               addr_valid,
  output logic               addr_ready,
  output logic [DW+AW-1:0]   pkt_out,
  output logic               pkt_valid,
  input  logic               pkt_ready
`ifdef BIT_MERGER_COUNT_EN
  ,
  output logic [15:0]        pkt_count
`endif
);

  localparam int unsigned PW = DW + AW;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fifo_state_e;

  logic [DW-1:0] data_hold_q, data_hold_d;
  logic          data_held_q, data_held_d;
  logic [AW-1:0] addr_hold_q, addr_hold_d;
  logic          addr_held_q, addr_held_d;

  fifo_state_e   state_q;
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic          pkt_valid_q;

  logic          pop;
  logic          fifo_space;
  logic          merge_fire;
  logic          data_acc;
  logic          addr_acc;
  logic [PW-1:0] merged;

  // Handshake decode; a held field frees its slot on the same edge it merges.
  always_comb begin
    pop         = pkt_valid_q & pkt_ready;
    fifo_space  = (state_q != FULL) | pop;
    merge_fire  = data_held_q & addr_held_q & fifo_space;
    data_ready  = ~data_held_q | merge_fire;
    addr_ready  = ~addr_held_q | merge_fire;
    data_acc    = data_valid & data_ready;
    addr_acc    = addr_valid & addr_ready;
    merged      = {addr_hold_q, data_hold_q};
    data_held_d = data_acc | (data_held_q & ~merge_fire);
    addr_held_d = addr_acc | (addr_held_q & ~merge_fire);
    data_hold_d = data_acc ? data_in : data_hold_q;
    addr_hold_d = addr_acc ? addr_in : addr_hold_q;
  end

  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      data_hold_q <= '0;
      data_held_q <= 1'b0;
      addr_hold_q <= '0;
      addr_held_q <= 1'b0;
    end else begin
      data_hold_q <= data_hold_d;
      data_held_q <= data_held_d;
      addr_hold_q <= addr_hold_d;
      addr_held_q <= addr_held_d;
    end
  end

  // Output FIFO: head_q is always the oldest unpopped packet.
  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      state_q     <= EMPTY;
      head_q      <= '0;
      tail_q      <= '0;
      pkt_valid_q <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (merge_fire) begin
            head_q      <= merged;
            state_q     <= ONE;
            pkt_valid_q <= 1'b1;
          end
        end
        ONE: begin
          if (merge_fire && !pop) begin
            tail_q  <= merged;
            state_q <= FULL;
          end else if (!merge_fire && pop) begin
            state_q     <= EMPTY;
            pkt_valid_q <= 1'b0;
          end else if (merge_fire && pop) begin
            head_q <= merged;
          end
        end
        FULL: begin
          if (pop) begin
            head_q <= tail_q;
            if (merge_fire) begin
              tail_q <= merged;
            end else begin
              state_q <= ONE;
            end
          end
        end
        default: begin
          state_q     <= EMPTY;
          pkt_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign pkt_out   = head_q;
  assign pkt_valid = pkt_valid_q;

`ifdef BIT_MERGER_COUNT_EN
  logic [15:0] pkt_count_q;

  // Free-running pop counter, wraps naturally at 16 bits.
  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      pkt_count_q <= '0;
    end else if (pop) begin
      pkt_count_q <= pkt_count_q + 16'd1;
    end
  end

  assign pkt_count = pkt_count_q;
`endif

endmodule

// File: tb/tb_bit_merger.sv
// Bench for bit_merger: a pairing model (k-th data with k-th address) checks every
// output cycle, plus directed scenarios with literal expectations.
module tb_bit_merger;

  localparam int unsigned DW = 7;
  localparam int unsigned AW = 4;
  localparam int unsigned PW = DW + AW;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] data_in;
  logic          data_valid;
  logic          data_ready;
  logic [AW-1:0] addr_in;
  logic          addr_valid;
  logic          addr_ready;
  logic [PW-1:0] pkt_out;
  logic          pkt_valid;
  logic          pkt_ready;
`ifdef BIT_MERGER_COUNT_EN
  logic [15:0]   pkt_count;
`endif

  bit_merger #(.DW(DW), .AW(AW)) dut (
    .CLK        (clk),
    ._RESET     (rst_n),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .addr_in    (addr_in),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready),
    .pkt_out    (pkt_out),
    .pkt_valid  (pkt_valid),
    .pkt_ready  (pkt_ready)
`ifdef BIT_MERGER_COUNT_EN
    ,
    .pkt_count  (pkt_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int pops_total = 0;
  int pops_since_rst = 0;
  int stalls = 0;
  bit rand_bp = 1'b0;

  logic [DW-1:0] dq[$];
  logic [AW-1:0] aq[$];
  bit            hold_prev = 1'b0;
  logic [PW-1:0] prev_out;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Model: packets leave in order as {k-th accepted address, k-th accepted data}.
  always @(negedge clk) begin
    if (!rst_n) begin
      dq.delete();
      aq.delete();
      hold_prev = 1'b0;
      pops_since_rst = 0;
    end else begin
      if (hold_prev) begin
        check("stall_valid", 32'(pkt_valid), 32'd1);
        check("stall_stable", 32'(pkt_out), 32'(prev_out));
      end
      if (pkt_valid) begin
        if (dq.size() > 0 && aq.size() > 0)
          check("head_pkt", 32'(pkt_out), 32'({aq[0], dq[0]}));
        else
          check("valid_without_pair", 32'(pkt_valid), 32'd0);
      end
`ifdef BIT_MERGER_COUNT_EN
      check("pkt_count", 32'(pkt_count), 32'(pops_since_rst % 65536));
`endif
      if (pkt_valid && pkt_ready) begin
        if (dq.size() > 0) void'(dq.pop_front());
        if (aq.size() > 0) void'(aq.pop_front());
        pops_total++;
        pops_since_rst++;
      end
      hold_prev = pkt_valid && !pkt_ready;
      prev_out  = pkt_out;
      if (data_valid && data_ready) dq.push_back(data_in);
      if (addr_valid && addr_ready) aq.push_back(addr_in);
    end
  end

  // Random output backpressure, changed just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (rand_bp) pkt_ready = 1'($urandom_range(0, 1));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one data/address pair together and wait until both are taken.
  task automatic send_pair(input logic [DW-1:0] d, input logic [AW-1:0] a);
    int n = 0;
    data_in    = d;
    addr_in    = a;
    data_valid = 1'b1;
    addr_valid = 1'b1;
    #1;
    while (!(data_ready && addr_ready) && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= 200) check("send_timeout", 32'(n), 32'd0);
    stalls += n;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    addr_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_dready"}, 32'(data_ready), 32'd1);
    check({tag, "_aready"}, 32'(addr_ready), 32'd1);
    check({tag, "_pvalid"}, 32'(pkt_valid), 32'd0);
    check({tag, "_pout"}, 32'(pkt_out), 32'd0);
`ifdef BIT_MERGER_COUNT_EN
    check({tag, "_pcount"}, 32'(pkt_count), 32'd0);
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int st;
    logic [PW-1:0] vv;

    rst_n      = 1'b0;
    data_in    = '0;
    addr_in    = '0;
    data_valid = 1'b0;
    addr_valid = 1'b0;
    pkt_ready  = 1'b0;

    #2;
    check_reset_outputs("rst_t0");
    #15;
    check_reset_outputs("rst_clk");
    #4;
    rst_n = 1'b1;
    step();

    // Data first, address three cycles later.
    pkt_ready  = 1'b1;
    data_in    = 7'h55;
    data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    check("wait_dready", 32'(data_ready), 32'd0);
    check("wait_aready", 32'(addr_ready), 32'd1);
    step();
    step();
    addr_in    = 4'hA;
    addr_valid = 1'b1;
    step();
    addr_valid = 1'b0;
    check("lat_accept_edge", 32'(pkt_valid), 32'd0);
    step();
    check("lat_valid", 32'(pkt_valid), 32'd1);
    check("lat_pkt", 32'(pkt_out), 32'h555);
    step();
    check("lat_popped", 32'(pkt_valid), 32'd0);

    // Same-edge fields under 5+ cycles of backpressure.
    pkt_ready = 1'b0;
    base = pops_total;
    send_pair(7'h01, 4'h3);
    step();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(pkt_valid), 32'd1);
      check("bp_pkt", 32'(pkt_out), 32'h181);
      step();
    end
    pkt_ready = 1'b1;
    step();
    check("bp_single_pop", 32'(pops_total - base), 32'd1);
    check("bp_empty", 32'(pkt_valid), 32'd0);

    // Ten-packet stream: fill two entries plus a held pair, then drain.
    pkt_ready = 1'b0;
    base = pops_total;
    for (int i = 0; i < 3; i++) send_pair(7'(i), 4'(i % 16));
    check("full_dready", 32'(data_ready), 32'd0);
    check("full_aready", 32'(addr_ready), 32'd0);
    check("full_valid", 32'(pkt_valid), 32'd1);
    pkt_ready = 1'b1;
    for (int i = 3; i < 10; i++) send_pair(7'(i), 4'(i % 16));
    repeat (4) step();
    check("stream_pops", 32'(pops_total - base), 32'd10);
    check("stream_empty", 32'(pkt_valid), 32'd0);

    // Sustained throughput from a fresh reset.
    #2;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    pkt_ready = 1'b1;
    base = pops_total;
    st = stalls;
    for (int k = 1; k <= 20; k++) begin
      send_pair(7'(k), 4'(k % 16));
      check("thru_valid", 32'(pkt_valid), (k >= 2) ? 32'd1 : 32'd0);
    end
    step();
    check("thru_last_valid", 32'(pkt_valid), 32'd1);
    step();
    check("thru_drained", 32'(pkt_valid), 32'd0);
    check("thru_pops", 32'(pops_total - base), 32'd20);
    check("thru_no_stall", 32'(stalls - st), 32'd0);
`ifdef BIT_MERGER_COUNT_EN
    check("thru_count", 32'(pkt_count), 32'd20);
`endif

    // Reset while FULL with both fields held.
    pkt_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_pair(7'(100 + i), 4'(5 + i));
    check("pre_rst_dready", 32'(data_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    step();
    check_reset_outputs("rst_mid_edge");
    #2;
    rst_n = 1'b1;
    pkt_ready = 1'b1;
    repeat (5) begin
      step();
      check("no_stale", 32'(pkt_valid), 32'd0);
    end
    send_pair(7'h2A, 4'h6);
    check("post_rst_accept", 32'(pkt_valid), 32'd0);
    step();
    check("post_rst_valid", 32'(pkt_valid), 32'd1);
    check("post_rst_pkt", 32'(pkt_out), 32'h32A);
    step();

    // Loopback of every nonzero 11-bit value split as a slicer would, random backpressure.
    base = pops_total;
    rand_bp = 1'b1;
    for (int v = 1; v < 2048; v++) begin
      vv = 11'(v);
      send_pair(vv[DW-1:0], vv[PW-1:DW]);
    end
    rand_bp = 1'b0;
    step();
    pkt_ready = 1'b1;
    repeat (4) step();
    check("loop_pops", 32'(pops_total - base), 32'd2047);
    check("loop_empty", 32'(pkt_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
